// File: rtl/atm_dispense_arbiter.sv
// atm_dispense_arbiter: round-robin owner of the shared cash dispenser.
// Grants one ATM session at a time, checks the vault, paces notes out and reports done/deny.
module atm_dispense_arbiter #(
  parameter int N_REQ      = 4,
  parameter int AMT_W      = 4,
  parameter int VAULT_W    = 10,
  parameter int VAULT_INIT = 500,
  parameter int GAP_CYC    = 2,
  parameter int LOW_THR    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*AMT_W-1:0]   amount,
  input  logic                     refill,
  input  logic [VAULT_W-1:0]       refill_amt,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         deny,
  output logic                     note_out,
  output logic                     busy,
  output logic [VAULT_W-1:0]       vault_count,
  output logic                     low_cash
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_NOTE   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_REJECT = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [VAULT_W-1:0] vault_q, vault_d;

  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic               pick_vld;
  logic [VAULT_W:0]   vault_sum;

  function automatic logic [VAULT_W-1:0] sat_vault(input logic [VAULT_W:0] v);
    return v[VAULT_W] ? {VAULT_W{1'b1}} : v[VAULT_W-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Round-robin search starting just after the previous winner.
  always_comb begin
    pick     = last_q;
    cand     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Refill and a note decrement can land in the same cycle; one extra bit catches overflow.
  always_comb begin
    vault_sum = {1'b0, vault_q}
              + (refill ? {1'b0, refill_amt} : {(VAULT_W+1){1'b0}})
              - {{VAULT_W{1'b0}}, note_out};
    vault_d   = sat_vault(vault_sum);
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_CHECK;
          win_d   = pick;
          last_d  = pick;
          rem_d   = amount[pick*AMT_W +: AMT_W];
        end
      end
      S_CHECK: begin
        if (rem_q == '0 ||
            ({{VAULT_W{1'b0}}, rem_q} > {{AMT_W{1'b0}}, vault_q}))
          state_d = S_REJECT;
        else
          state_d = S_NOTE;
      end
      S_NOTE: begin
        rem_d   = rem_q - 1'b1;
        gap_d   = GAP_W'(GAP_CYC - 1);
        state_d = (rem_q == AMT_W'(1)) ? S_FINISH : S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0)
          state_d = S_NOTE;
        else
          gap_d = gap_q - 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      vault_q <= VAULT_W'(VAULT_INIT);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      vault_q <= vault_d;
    end
  end

  // Owner index, note countdown and gap timer are only meaningful while busy.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    rem_q <= rem_d;
    gap_q <= gap_d;
  end

  assign busy        = (state_q != S_IDLE);
  assign grant       = busy ? onehot(win_q) : '0;
  assign done        = (state_q == S_FINISH) ? onehot(win_q) : '0;
  assign deny        = (state_q == S_REJECT) ? onehot(win_q) : '0;
  assign note_out    = (state_q == S_NOTE);
  assign vault_count = vault_q;
  assign low_cash    = (vault_q < VAULT_W'(LOW_THR));

endmodule

// File: tb/tb_atm_dispense_arbiter.sv
// Bench for atm_dispense_arbiter: directed scenarios plus randomized requesters,
// every cycle compared against a transaction-schedule model of the dispenser.
module tb_atm_dispense_arbiter;

  localparam int N_REQ      = 4;
  localparam int AMT_W      = 4;
  localparam int VAULT_W    = 10;
  localparam int VAULT_INIT = 500;
  localparam int GAP_CYC    = 2;
  localparam int LOW_THR    = 20;
  localparam int VMAX       = (1 << VAULT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*AMT_W-1:0] amount;
  logic                   refill;
  logic [VAULT_W-1:0]     refill_amt;
  logic [N_REQ-1:0]       grant, done, deny;
  logic                   note_out, busy, low_cash;
  logic [VAULT_W-1:0]     vault_count;

  int total = 0;
  int bad   = 0;

  // model state: one active transaction described by owner, amount, age and length
  int m_busy, m_owner, m_amt, m_t, m_len, m_rej, m_last, m_vault;
  bit drop_pend [N_REQ];
  int winners [$];

  always #5 clk = ~clk;

  atm_dispense_arbiter #(
    .N_REQ(N_REQ), .AMT_W(AMT_W), .VAULT_W(VAULT_W),
    .VAULT_INIT(VAULT_INIT), .GAP_CYC(GAP_CYC), .LOW_THR(LOW_THR)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount),
    .refill(refill), .refill_amt(refill_amt),
    .grant(grant), .done(done), .deny(deny), .note_out(note_out),
    .busy(busy), .vault_count(vault_count), .low_cash(low_cash)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_note();
    int period;
    period = GAP_CYC + 1;
    if (m_busy == 0 || m_rej != 0 || m_t < 1) return 0;
    if (m_t > 1 + (m_amt - 1) * period) return 0;
    return (((m_t - 1) % period) == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_last  = N_REQ - 1;
    m_vault = VAULT_INIT;
  endtask

  task automatic model_step();
    int nv;
    int found;
    nv = m_vault + (refill ? int'(refill_amt) : 0) - m_note();
    m_vault = (nv > VMAX) ? VMAX : nv;
    if (m_busy != 0) begin
      m_t++;
      if (m_t == m_len) m_busy = 0;
    end else if (req != '0) begin
      found = 0;
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (m_last + k) % N_REQ;
        if (found == 0 && req[c]) begin
          m_owner = c;
          found   = 1;
        end
      end
      m_last = m_owner;
      m_amt  = int'(amount[m_owner*AMT_W +: AMT_W]);
      m_rej  = (m_amt == 0 || m_amt > m_vault) ? 1 : 0;
      m_t    = 0;
      m_len  = (m_rej != 0) ? 2 : 2 + m_amt + (m_amt - 1) * GAP_CYC;
      m_busy = 1;
    end
  endtask

  task automatic model_check();
    logic [N_REQ-1:0] eg;
    eg = (m_busy != 0) ? N_REQ'(1 << m_owner) : '0;
    check("grant", grant, eg);
    check("done", done, (m_busy != 0 && m_rej == 0 && m_t == m_len - 1) ? eg : '0);
    check("deny", deny, (m_busy != 0 && m_rej != 0 && m_t == 1) ? eg : '0);
    check("note_out", note_out, m_note());
    check("busy", busy, (m_busy != 0) ? 1 : 0);
    check("vault", vault_count, m_vault);
    check("low_cash", low_cash, (m_vault < LOW_THR) ? 1 : 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      @(negedge clk);
      if (rst) model_reset();
      model_check();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_amt(input int i, input int a);
    amount[i*AMT_W +: AMT_W] = AMT_W'(a);
  endtask

  // wait for the owner's done/deny, then drop req in the following cycle
  task automatic wait_pulse(input int i);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      seen = done[i] | deny[i];
    end
    check("pulse_seen", seen, 1);
    tick();
    req[i] = 1'b0;
  endtask

  task automatic do_txn(input int i, input int a);
    set_amt(i, a);
    req[i] = 1'b1;
    wait_pulse(i);
  endtask

  initial begin
    int amt;
    rst = 1'b1; req = '0; amount = '0; refill = 1'b0; refill_amt = '0;
    tick(); tick();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_vault", vault_count, VAULT_INIT);
    check("rst_note", note_out, 0);
    check("rst_done", done | deny, 0);
    rst = 1'b0;
    tick();

    // single request: amount 3 from requester 0
    set_amt(0, 3); req[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check("single_grant", grant[0], (c <= 9) ? 1 : 0);
      check("single_note", note_out, (c == 2 || c == 5 || c == 8) ? 1 : 0);
      check("single_done", done[0], (c == 9) ? 1 : 0);
    end
    req[0] = 1'b0;
    check("single_vault", vault_count, 497);
    check("single_low", low_cash, 0);

    // refill landing in a NOTE cycle
    tick();
    set_amt(0, 2); req[0] = 1'b1;
    tick(); tick();
    check("refill_note", note_out, 1);
    refill = 1'b1; refill_amt = 100;
    tick();
    refill = 1'b0;
    check("refill_net", vault_count, 596);
    wait_pulse(0);
    check("refill_end", vault_count, 595);

    // round robin between requesters 1 and 3
    tick();
    set_amt(1, 1); set_amt(3, 1); req[1] = 1'b1; req[3] = 1'b1;
    begin
      logic [N_REQ-1:0] prev;
      prev = '0;
      for (int c = 0; c < 24; c++) begin
        tick();
        if (grant != '0 && prev == '0)
          for (int i = 0; i < N_REQ; i++) if (grant[i]) winners.push_back(i);
        prev = grant;
      end
    end
    req = '0;
    repeat (6) tick();
    check("rr_count", (winners.size() >= 4) ? 1 : 0, 1);
    for (int j = 0; j < 4 && j < winners.size(); j++)
      check("rr_order", winners[j], (j % 2 == 0) ? 1 : 3);

    // drain the vault down to 5 notes
    for (int n = 0; n < 100 && m_vault > 5; n++) begin
      tick();
      amt = (m_vault - 5 > 15) ? 15 : m_vault - 5;
      do_txn(0, amt);
    end
    check("drain_vault", vault_count, 5);
    check("drain_low", low_cash, 1);

    // insufficient funds, then zero amount
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      set_amt(2, (pass == 0) ? 6 : 0); req[2] = 1'b1;
      for (int c = 1; c <= 3; c++) begin
        tick();
        check("deny_pulse", deny[2], (c == 2) ? 1 : 0);
        check("deny_grant", grant[2], (c <= 2) ? 1 : 0);
        check("deny_note", note_out, 0);
        check("deny_done", done[2], 0);
      end
      req[2] = 1'b0;
      check("deny_vault", vault_count, 5);
    end

    // saturating refill near the top
    tick();
    refill = 1'b1; refill_amt = 1023;
    tick();
    refill = 1'b0;
    check("sat_vault", vault_count, 1023);
    check("sat_low", low_cash, 0);

    // reset after the 2nd of 5 notes
    tick();
    set_amt(0, 5); req[0] = 1'b1;
    repeat (5) tick();
    check("mid_note2", note_out, 1);
    tick();
    rst = 1'b1; req = '0;
    #1;
    check("mid_grant", grant, 0);
    check("mid_busy", busy, 0);
    check("mid_note", note_out, 0);
    check("mid_pulses", done | deny, 0);
    check("mid_vault", vault_count, VAULT_INIT);
    tick(); tick();
    check("mid_nodone", done, 0);
    rst = 1'b0;
    tick();
    set_amt(0, 1); set_amt(3, 1); req[0] = 1'b1; req[3] = 1'b1;
    tick();
    check("post_rst_winner", grant, 4'b0001);
    wait_pulse(0);
    wait_pulse(3);

    // randomized requesters obeying the handshake, with sporadic refills
    for (int cyc = 0; cyc < 2500; cyc++) begin
      tick();
      refill     = ($urandom_range(0, 47) == 0);
      refill_amt = VAULT_W'($urandom_range(0, 60));
      for (int i = 0; i < N_REQ; i++) begin
        if (drop_pend[i]) begin
          req[i] = 1'b0;
          drop_pend[i] = 1'b0;
        end else if (req[i]) begin
          if (done[i] | deny[i]) drop_pend[i] = 1'b1;
        end else if ($urandom_range(0, 3) == 0) begin
          set_amt(i, $urandom_range(0, 15));
          req[i] = 1'b1;
        end
      end
    end
    refill = 1'b0;
    req = '0;
    repeat (60) tick();
    check("end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
